// File: rtl/keycode_decoder_if.sv
// rtl/keycode_decoder_if.sv - keypad-to-calculator command bus
// master drives keys and cmd_ready; slave is the decoder.
interface keycode_decoder_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic [3:0]   keycode;
    logic         keystrobe;
    logic         cmd_ready;
    logic         cmd_valid;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sel;
    logic [W-1:0] disp_bcd;
    logic         key_err;

    modport master (
        output keycode, keystrobe, cmd_ready,
        input  cmd_valid, op_a, op_b, op_sel, disp_bcd, key_err
    );

    modport slave (
        input  keycode, keystrobe, cmd_ready,
        output cmd_valid, op_a, op_b, op_sel, disp_bcd, key_err
    );
endinterface

// File: rtl/keycode_decoder.sv
// rtl/keycode_decoder.sv - keypad presses to {A, op, B} calculator commands
// Optional KEYCODE_DECODER_OPREPLACE_EN: add/sub before any B digit replaces the operator.
module keycode_decoder #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    keycode_decoder_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    localparam logic [3:0] KEY_ENTER = 4'd12;
    localparam logic [3:0] KEY_MULTI = 4'd15;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        PEND    = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_q, a_nx;
    logic [W-1:0]    b_q, b_nx;
    logic [CW-1:0]   cnt_a_q, cnt_a_nx;
    logic [CW-1:0]   cnt_b_q, cnt_b_nx;
    logic            op_sel_q, op_sel_nx;
    logic            strb_q;
    logic            key_err_q, err_nx;
    logic            clear_all;

    logic key_event;
    logic is_digit;
    logic is_op;

    // strb_q resets high so a key held across reset release is not an event
    assign key_event = bus.keystrobe & ~strb_q;
    assign is_digit  = (bus.keycode <= 4'd9);
    assign is_op     = (bus.keycode == 4'd10) || (bus.keycode == 4'd11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ENTER_A;
            a_q       <= '0;
            b_q       <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            op_sel_q  <= 1'b0;
            strb_q    <= 1'b1;
            key_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            a_q       <= a_nx;
            b_q       <= b_nx;
            cnt_a_q   <= cnt_a_nx;
            cnt_b_q   <= cnt_b_nx;
            op_sel_q  <= op_sel_nx;
            strb_q    <= bus.keystrobe;
            key_err_q <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        a_nx      = a_q;
        b_nx      = b_q;
        cnt_a_nx  = cnt_a_q;
        cnt_b_nx  = cnt_b_q;
        op_sel_nx = op_sel_q;
        err_nx    = 1'b0;
        clear_all = 1'b0;

        unique case (state)
            ENTER_A: begin
                if (key_event) begin
                    if (is_digit) begin
                        if (cnt_a_q < CNT_MAX) begin
                            a_nx     = {a_q[W-5:0], bus.keycode};
                            cnt_a_nx = cnt_a_q + 1'b1;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end else if (is_op) begin
                        if (cnt_a_q != '0) begin
                            op_sel_nx = bus.keycode[0];
                            b_nx      = '0;
                            cnt_b_nx  = '0;
                            state_nx  = ENTER_B;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end else if (bus.keycode == KEY_ENTER) begin
                        err_nx = 1'b1;
                    end else if (bus.keycode == KEY_MULTI) begin
                        clear_all = 1'b1;
                        err_nx    = 1'b1;
                    end
                end
            end
            ENTER_B: begin
                if (key_event) begin
                    if (is_digit) begin
                        if (cnt_b_q < CNT_MAX) begin
                            b_nx     = {b_q[W-5:0], bus.keycode};
                            cnt_b_nx = cnt_b_q + 1'b1;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end else if (is_op) begin
`ifdef KEYCODE_DECODER_OPREPLACE_EN
                        if (cnt_b_q == '0) begin
                            op_sel_nx = bus.keycode[0];
                        end else begin
                            err_nx = 1'b1;
                        end
`else
                        err_nx = 1'b1;
`endif
                    end else if (bus.keycode == KEY_ENTER) begin
                        if (cnt_b_q != '0) begin
                            state_nx = PEND;
                        end else begin
                            err_nx = 1'b1;
                        end
                    end else if (bus.keycode == KEY_MULTI) begin
                        clear_all = 1'b1;
                        err_nx    = 1'b1;
                    end
                end
            end
            PEND: begin
                // keys are dropped silently while the command waits
                if (bus.cmd_ready) begin
                    clear_all = 1'b1;
                end
            end
            default: begin
                clear_all = 1'b1;
            end
        endcase

        if (clear_all) begin
            a_nx      = '0;
            b_nx      = '0;
            cnt_a_nx  = '0;
            cnt_b_nx  = '0;
            op_sel_nx = 1'b0;
            state_nx  = ENTER_A;
        end
    end

    always_comb begin
        bus.cmd_valid = (state == PEND);
        bus.op_a      = a_q;
        bus.op_b      = b_q;
        bus.op_sel    = op_sel_q;
        bus.disp_bcd  = (state == ENTER_A) ? a_q : b_q;
        bus.key_err   = key_err_q;
    end
endmodule

// File: tb/tb_keycode_decoder.sv
// tb/tb_keycode_decoder.sv - random and directed checks of keycode_decoder
// against a digit-queue model of the keypad command rules.
module tb_keycode_decoder;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MA = 0, MB = 1, MP = 2;

    logic tb_clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic chk_en  = 1'b0;
    logic e;

    keycode_decoder_if #(.DIGITS(DIGITS)) bus ();

    keycode_decoder #(.DIGITS(DIGITS)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 tb_clk = ~tb_clk;

    int   qa[$];
    int   qb[$];
    int   m_state;
    logic m_op;
    logic m_err;
    logic m_strb;
    logic m_ev;
    int   m_k;

    function automatic logic [W-1:0] pack(input int q[$]);
        logic [W-1:0] v;
        v = '0;
        foreach (q[i]) v = v * 16 + W'(q[i]);
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge tb_clk or posedge rst) begin
        if (rst) begin
            m_state = MA;
            qa.delete();
            qb.delete();
            m_op   = 1'b0;
            m_err  = 1'b0;
            m_strb = 1'b1;
        end else begin
            m_ev  = bus.keystrobe && !m_strb;
            m_k   = int'(bus.keycode);
            m_err = 1'b0;
            if (m_state == MP) begin
                if (bus.cmd_ready) begin
                    qa.delete(); qb.delete(); m_op = 1'b0; m_state = MA;
                end
            end else if (m_ev) begin
                if (m_k <= 9) begin
                    if (m_state == MA) begin
                        if (qa.size() < DIGITS) qa.push_back(m_k); else m_err = 1'b1;
                    end else begin
                        if (qb.size() < DIGITS) qb.push_back(m_k); else m_err = 1'b1;
                    end
                end else if (m_k == 15) begin
                    qa.delete(); qb.delete(); m_op = 1'b0; m_state = MA; m_err = 1'b1;
                end else if (m_k == 12) begin
                    if (m_state == MB && qb.size() > 0) m_state = MP; else m_err = 1'b1;
                end else if (m_k == 10 || m_k == 11) begin
                    if (m_state == MA) begin
                        if (qa.size() > 0) begin
                            m_op = (m_k == 11); qb.delete(); m_state = MB;
                        end else m_err = 1'b1;
                    end else begin
`ifdef KEYCODE_DECODER_OPREPLACE_EN
                        if (qb.size() == 0) m_op = (m_k == 11); else m_err = 1'b1;
`else
                        m_err = 1'b1;
`endif
                    end
                end
            end
            m_strb = bus.keystrobe;
        end
    end

    always @(negedge tb_clk) begin
        if (chk_en) begin
            check("cmd_valid", W'(bus.cmd_valid), W'(m_state == MP));
            check("op_a", bus.op_a, pack(qa));
            check("op_b", bus.op_b, pack(qb));
            check("op_sel", W'(bus.op_sel), W'(m_op));
            check("disp_bcd", bus.disp_bcd, (m_state == MA) ? pack(qa) : pack(qb));
            check("key_err", W'(bus.key_err), W'(m_err));
        end
    end

    task automatic step();
        @(posedge tb_clk);
        #2;
    endtask

    task automatic press(input logic [3:0] k, output logic err);
        bus.keycode   = k;
        bus.keystrobe = 1'b1;
        step();
        err = bus.key_err;
        step();
        step();
        bus.keystrobe = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.keystrobe = 1'b1;
        bus.keycode   = 4'd5;
        bus.cmd_ready = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;

        // key held across reset release
        rst = 1'b0;
        step();
        step();
        check("held_disp", bus.disp_bcd, 16'h0000);
        check("held_err", W'(bus.key_err), '0);
        bus.keystrobe = 1'b0;
        step();
        step();
        press(4'd5, e);
        check("after_held_disp", bus.disp_bcd, 16'h0005);
        press(4'd15, e);
        check("clear_err", W'(e), W'(1));

        // 12 + 3 with the core stalled
        press(4'd1, e); press(4'd2, e); press(4'd10, e); press(4'd3, e); press(4'd12, e);
        check("cmd_valid_up", W'(bus.cmd_valid), W'(1));
        check("cmd_op_a", bus.op_a, 16'h0012);
        check("cmd_op_b", bus.op_b, 16'h0003);
        check("cmd_op_sel", W'(bus.op_sel), '0);
        repeat (5) step();
        check("cmd_hold_a", bus.op_a, 16'h0012);
        check("cmd_hold_valid", W'(bus.cmd_valid), W'(1));
        bus.cmd_ready = 1'b1;
        step();
        check("xfer_valid", W'(bus.cmd_valid), '0);
        check("xfer_disp", bus.disp_bcd, 16'h0000);
        bus.cmd_ready = 1'b0;
        step();

        // digit overflow
        repeat (4) press(4'd9, e);
        check("nines", bus.op_a, 16'h9999);
        press(4'd9, e);
        check("ninth_err", W'(e), W'(1));
        check("nines_kept", bus.op_a, 16'h9999);
        press(4'd15, e);

        // illegal keys in ENTER_A, then multi-key abort from ENTER_B
        press(4'd12, e);
        check("enter_first_err", W'(e), W'(1));
        press(4'd11, e);
        check("sub_first_err", W'(e), W'(1));
        press(4'd7, e);
        press(4'd11, e);
        check("sub_ok", W'(e), '0);
        press(4'd15, e);
        check("multi_err", W'(e), W'(1));
        check("multi_a", bus.op_a, 16'h0000);
        press(4'd6, e);
        check("back_in_a", bus.disp_bcd, 16'h0006);
        press(4'd15, e);

        // operator replacement
        press(4'd4, e); press(4'd10, e); press(4'd11, e);
`ifdef KEYCODE_DECODER_OPREPLACE_EN
        check("opr_err", W'(e), '0);
        check("opr_sel", W'(bus.op_sel), W'(1));
`else
        check("opr_err", W'(e), W'(1));
        check("opr_sel", W'(bus.op_sel), '0);
`endif
        press(4'd15, e);

        // key and reset during PEND
        press(4'd1, e); press(4'd10, e); press(4'd2, e); press(4'd12, e);
        bus.keycode   = 4'd8;
        bus.keystrobe = 1'b1;
        step();
        check("pend_key_err", W'(bus.key_err), '0);
        check("pend_op_b", bus.op_b, 16'h0002);
        check("pend_valid", W'(bus.cmd_valid), W'(1));
        rst = 1'b1;
        #1;
        check("rst_valid", W'(bus.cmd_valid), '0);
        check("rst_op_a", bus.op_a, 16'h0000);
        check("rst_op_b", bus.op_b, 16'h0000);
        step();
        rst = 1'b0;
        bus.keystrobe = 1'b0;
        step();

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 31));
            if (r < 20)       bus.keycode = 4'(r % 10);
            else if (r < 24)  bus.keycode = 4'(10 + (r % 2));
            else if (r < 28)  bus.keycode = 4'd12;
            else if (r == 28) bus.keycode = 4'd13;
            else if (r == 29) bus.keycode = 4'd14;
            else if (r == 30) bus.keycode = 4'd15;
            else              bus.keycode = 4'd0;
            if ($urandom_range(0, 2) == 0) bus.keystrobe = ~bus.keystrobe;
            bus.cmd_ready = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
